// File: rtl/life_game_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | life_game_controller_if : buttons/frame timing in, run strobe out   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface life_game_controller_if #(
  parameter int GEN_WIDTH = 16
);
  logic [3:0]           button;
  logic                 frame_start;
  logic                 run;
  logic                 running;
  logic [2:0]           speed;
  logic [GEN_WIDTH-1:0] generation;

  modport master (output button, frame_start,
                  input  run, running, speed, generation);
  modport slave  (input  button, frame_start,
                  output run, running, speed, generation);
endinterface
`default_nettype wire

// File: rtl/life_game_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | life_game_controller : debounced run/step/speed control, emits a    |
// | frame-aligned one-cycle run strobe per generation                   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module life_game_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SPEED       = 7,
  parameter int DEFAULT_SPEED   = 4,
  parameter int GEN_WIDTH       = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  life_game_controller_if.slave bus
);

  localparam int              CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int              FC_W      = (MAX_SPEED > 0) ? MAX_SPEED : 1;
  localparam logic [2:0]      SPEED_MAX = 3'(MAX_SPEED);
  localparam logic [2:0]      SPEED_RST = 3'(DEFAULT_SPEED);

  typedef enum logic [1:0] {
    S_PAUSED       = 2'd0,
    S_RUNNING      = 2'd1,
    S_STEP_PENDING = 2'd2
  } state_t;

  logic [3:0] press;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count samples disagreeing with the accepted level; the Nth flips it.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) level_d = sync2_q;
        else                   cnt_d   = cnt_q + 1'b1;
      end
    end

    assign press[b] = level_d & ~level_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= bus.button[b];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic                 running_q, running_d;
  logic [2:0]           speed_q, speed_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic [FC_W-1:0]      period_last;
  logic                 toggle, step, up, down;

  assign toggle = press[0];
  assign step   = press[1];
  assign up     = press[2];
  assign down   = press[3];

  // Period is 2^(MAX_SPEED-speed) frames, so its last count is all-ones shifted.
  assign period_last = {FC_W{1'b1}} >> speed_q;

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    speed_d     = speed_q;
    gen_d       = gen_q + GEN_WIDTH'(run_q);

    case (state_q)
      S_PAUSED: begin
        if (toggle) begin
          state_d     = S_RUNNING;
          frame_cnt_d = '0;
        end else if (step) begin
          state_d = S_STEP_PENDING;
        end
      end
      S_RUNNING: begin
        if (bus.frame_start) begin
          if (frame_cnt_q == period_last) begin
            run_d       = 1'b1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        if (toggle) state_d = S_PAUSED;
      end
      S_STEP_PENDING: begin
        if (toggle) begin
          state_d     = S_RUNNING;
          frame_cnt_d = '0;
        end else if (bus.frame_start) begin
          run_d   = 1'b1;
          state_d = S_PAUSED;
        end
      end
      default: state_d = S_PAUSED;
    endcase

    if (up && !down && speed_q != SPEED_MAX)
      speed_d = speed_q + 3'd1;
    else if (down && !up && speed_q != 3'd0)
      speed_d = speed_q - 3'd1;
    if (speed_d != speed_q) frame_cnt_d = '0;

    running_d = (state_d == S_RUNNING);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_PAUSED;
      run_q       <= 1'b0;
      running_q   <= 1'b0;
      speed_q     <= SPEED_RST;
      frame_cnt_q <= '0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      running_q   <= running_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
      gen_q       <= gen_d;
    end
  end

  assign bus.run        = run_q;
  assign bus.running    = running_q;
  assign bus.speed      = speed_q;
  assign bus.generation = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_game_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_life_game_controller : directed vectors for life_game_controller |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_life_game_controller;

  localparam int OP_PRESS  = 0;
  localparam int OP_FRAMES = 1;

  typedef struct {
    int         op;
    logic [3:0] btn;
    int         n;
    logic       exp_running;
    logic [2:0] exp_speed;
    logic [3:0] exp_gen;
    int         exp_runs;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   run_cnt = 0;
  int   viol = 0;
  logic fs_seen = 1'b0;
  logic run_prev = 1'b0;
  vec_t vecs[$];

  life_game_controller_if #(.GEN_WIDTH(4)) bus ();

  life_game_controller #(
    .DEBOUNCE_CYCLES(4),
    .MAX_SPEED      (7),
    .DEFAULT_SPEED  (4),
    .GEN_WIDTH      (4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) fs_seen <= bus.frame_start;

  // Every run must follow a frame_start by one cycle and never repeat back-to-back.
  always @(negedge clk) begin
    if (bus.run === 1'b1) begin
      run_cnt++;
      if (fs_seen !== 1'b1) viol++;
      if (run_prev === 1'b1) viol++;
    end
    run_prev = bus.run;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      bus.button = mask;
      repeat (8) @(negedge clk);
      bus.button = 4'b0000;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    int base;
    vecs.push_back(vec_t'{OP_PRESS,  4'b0100,  3, 1'b1, 3'd7, 4'd0,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  5, 1'b1, 3'd7, 4'd5,  5});
    vecs.push_back(vec_t'{OP_PRESS,  4'b1000,  5, 1'b1, 3'd2, 4'd5,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000, 31, 1'b1, 3'd2, 4'd5,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  1, 1'b1, 3'd2, 4'd6,  1});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000, 31, 1'b1, 3'd2, 4'd6,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  1, 1'b1, 3'd2, 4'd7,  1});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0001,  1, 1'b0, 3'd2, 4'd7,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  3, 1'b0, 3'd2, 4'd7,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0010,  1, 1'b0, 3'd2, 4'd7,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0010,  1, 1'b0, 3'd2, 4'd7,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  1, 1'b0, 3'd2, 4'd8,  1});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  2, 1'b0, 3'd2, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0100, 10, 1'b0, 3'd7, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b1000, 10, 1'b0, 3'd0, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0100,  3, 1'b0, 3'd3, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b1100,  1, 1'b0, 3'd3, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0100,  4, 1'b0, 3'd7, 4'd8,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0001,  1, 1'b1, 3'd7, 4'd8,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  7, 1'b1, 3'd7, 4'd15, 7});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  1, 1'b1, 3'd7, 4'd0,  1});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0001,  1, 1'b0, 3'd7, 4'd0,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0011,  1, 1'b1, 3'd7, 4'd0,  0});
    vecs.push_back(vec_t'{OP_PRESS,  4'b0010,  1, 1'b1, 3'd7, 4'd0,  0});
    vecs.push_back(vec_t'{OP_FRAMES, 4'b0000,  1, 1'b1, 3'd7, 4'd1,  1});

    bus.button      = 4'b0000;
    bus.frame_start = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_run",        int'(bus.run),        0);
    chk("reset_running",    int'(bus.running),    0);
    chk("reset_speed",      int'(bus.speed),      4);
    chk("reset_generation", int'(bus.generation), 0);
    rst = 1'b0;
    @(negedge clk);

    // Raw toggle edge must reach running exactly 2+DEBOUNCE_CYCLES cycles later.
    bus.button = 4'b0001;
    repeat (5) @(negedge clk);
    chk("toggle_latency_early", int'(bus.running), 0);
    @(negedge clk);
    chk("toggle_latency_exact", int'(bus.running), 1);
    repeat (4) @(negedge clk);
    bus.button = 4'b0000;
    repeat (8) @(negedge clk);

    bus.button = 4'b0001;
    repeat (3) @(negedge clk);
    bus.button = 4'b0000;
    repeat (10) @(negedge clk);
    chk("glitch_toggle", int'(bus.running), 1);
    bus.button = 4'b0100;
    repeat (3) @(negedge clk);
    bus.button = 4'b0000;
    repeat (10) @(negedge clk);
    chk("glitch_speed", int'(bus.speed), 4);

    for (int i = 0; i < vecs.size(); i++) begin
      base = run_cnt;
      if (vecs[i].op == OP_PRESS) press(vecs[i].btn, vecs[i].n);
      else                        frames(vecs[i].n);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_running", i), int'(bus.running),    int'(vecs[i].exp_running));
      chk($sformatf("v%0d_speed", i),   int'(bus.speed),      int'(vecs[i].exp_speed));
      chk($sformatf("v%0d_gen", i),     int'(bus.generation), int'(vecs[i].exp_gen));
      chk($sformatf("v%0d_runs", i),    run_cnt - base,       vecs[i].exp_runs);
    end

    // Reset landing between a qualifying frame_start and its strobe cancels it.
    base            = run_cnt;
    bus.frame_start = 1'b1;
    #2 rst          = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("abort_run",        int'(bus.run),        0);
    chk("abort_running",    int'(bus.running),    0);
    chk("abort_speed",      int'(bus.speed),      4);
    chk("abort_generation", int'(bus.generation), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_runs", run_cnt - base, 0);

    chk("run_timing_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
